// File: rtl/md5_pad_packer.sv
// md5_pad_packer: packs a little-endian 32-bit word stream into 512-bit MD5
// blocks. It inserts the 0x80 pad byte and the 64-bit bit-length field, and
// adds an extra trailing block when the length field does not fit.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. A source holds valid and its payload stable until that edge, and valid
// never depends on ready. Here in_ready is high only in FILL and blk_valid only
// in OUT, so the two handshakes can never happen in the same cycle.
module md5_pad_packer #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [1:0]   in_nbytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last,
  output logic         state_dbg
);

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [511:0]       blk_buf;
  logic [3:0]         widx;
  logic [LEN_W-1:0]   len;
  logic               pending_extra;
  logic               extra_has_pad;
  logic               first_pending;

  logic               in_fire;
  logic               blk_fire;
  logic [2:0]         nb;
  logic [31:0]        byte_mask;
  logic [31:0]        pad_word;
  logic [31:0]        wdata;
  logic [5:0]         len_add;
  logic [LEN_W-1:0]   len_inc;
  logic               fits;
  logic               block_done;
  logic [511:0]       buf_fill;
  logic [511:0]       extra_blk;

  assign in_ready  = (state == FILL) && !rst;
  assign in_fire   = in_valid && in_ready;
  assign blk_valid = (state == OUT);
  assign blk_fire  = blk_valid && blk_ready;
  assign blk_data  = blk_valid ? blk_buf : '0;
  assign state_dbg = state;

  // Decode the incoming word: byte count, masking, pad placement, new length.
  always_comb begin
    nb = (in_nbytes == 2'd0) ? 3'd4 : {1'b0, in_nbytes};
    byte_mask = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(nb)) byte_mask[8*k +: 8] = 8'hff;
    end
    pad_word = 32'h80 << {nb[1:0], 3'b000};
    wdata = in_data;
    if (in_last) begin
      wdata = in_data & byte_mask;
      if (nb != 3'd4) wdata = wdata | pad_word;
    end
    len_add = in_last ? {nb, 3'b000} : 6'd32;
    len_inc = len + {{(LEN_W-6){1'b0}}, len_add};
    // The length field fits when the 0x80 byte lands in word 13 or earlier.
    fits = in_last && (((nb != 3'd4) && (widx <= 4'd13)) ||
                       ((nb == 3'd4) && (widx <= 4'd12)));
    block_done = in_last || (widx == 4'd15);
  end

  // Build the buffer image after accepting the current word, and the extra block.
  always_comb begin
    buf_fill = blk_buf;
    buf_fill[{widx, 5'b00000} +: 32] = wdata;
    if (in_last && (nb == 3'd4) && (widx != 4'd15))
      buf_fill[{widx + 4'd1, 5'b00000} +: 32] = 32'h80;
    if (fits) buf_fill[511:448] = len_inc;
    extra_blk = '0;
    extra_blk[511:448] = len;
    if (!extra_has_pad) extra_blk[31:0] = 32'h80;
  end

  // Next-state logic: fill until a block is complete, then hold it until consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (in_fire && block_done) state_nxt = OUT;
      OUT:  if (blk_fire && !pending_extra) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Datapath: buffer writes, word index, length counter and block flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_buf       <= '0;
      widx          <= '0;
      len           <= '0;
      pending_extra <= 1'b0;
      extra_has_pad <= 1'b0;
      first_pending <= 1'b1;
      blk_first     <= 1'b0;
      blk_last      <= 1'b0;
    end else if (in_fire) begin
      blk_buf <= buf_fill;
      widx    <= widx + 4'd1;
      len     <= len_inc;
      if (block_done) begin
        blk_first     <= first_pending;
        first_pending <= 1'b0;
        blk_last      <= fits;
        if (in_last && !fits) begin
          pending_extra <= 1'b1;
          // Only a full last word in slot 15 leaves the pad byte for the extra block.
          extra_has_pad <= !((nb == 3'd4) && (widx == 4'd15));
        end
      end
    end else if (blk_fire) begin
      if (pending_extra) begin
        blk_buf       <= extra_blk;
        blk_first     <= 1'b0;
        blk_last      <= 1'b1;
        pending_extra <= 1'b0;
      end else begin
        blk_buf   <= '0;
        widx      <= '0;
        blk_first <= 1'b0;
        blk_last  <= 1'b0;
        if (blk_last) begin
          len           <= '0;
          first_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_md5_pad_packer.sv
// Directed bench for md5_pad_packer: a table of message lengths with
// hand-computed block counts and length words, a byte-level padding model
// feeding the scoreboard, and hand sequences for "abc" and mid-message reset.
module tb_md5_pad_packer;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [1:0]   in_nbytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         state_dbg;

  int checks = 0;
  int errors = 0;

  logic [7:0]   msg_bytes[$];
  logic [511:0] exp_q[$];
  logic [1:0]   exp_fl_q[$];

  typedef struct {
    int          nbytes;
    int          stall;
    int          exp_nblk;
    logic [31:0] exp_len;
  } vec_t;
  vec_t vecs[$];

  md5_pad_packer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_nbytes(in_nbytes),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last), .state_dbg(state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference padding on a byte array: append 0x80, zero-fill to 56 mod 64,
  // append the bit length little-endian, then slice into 64-byte blocks.
  function automatic void model_push();
    logic [7:0]   m[$];
    logic [63:0]  bitlen;
    logic [511:0] blk;
    int           nblk;
    m = msg_bytes;
    bitlen = 64'(msg_bytes.size()) * 64'd8;
    m.push_back(8'h80);
    while ((m.size() % 64) != 56) m.push_back(8'h00);
    for (int i = 0; i < 8; i++) m.push_back(bitlen[8*i +: 8]);
    nblk = m.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[8*j +: 8] = m[64*b + j];
      exp_q.push_back(blk);
      exp_fl_q.push_back({(b == 0), (b == nblk - 1)});
    end
  endfunction

  // Drive msg_bytes as words; stops after 'limit' words (no in_last if cut short).
  task automatic send_msg(input int limit);
    int total, nw, nb, cnt;
    logic [31:0] w;
    total = msg_bytes.size();
    nw = (total + 3) / 4;
    for (int i = 0; i < nw && i < limit; i++) begin
      @(negedge clk);
      w = '0;
      for (int k = 0; k < 4; k++) begin
        if (4*i + k < total) w[8*k +: 8] = msg_bytes[4*i + k];
        else                 w[8*k +: 8] = 8'($urandom_range(1, 255));
      end
      nb = total - 4*i;
      in_valid  = 1'b1;
      in_data   = w;
      in_last   = (i == nw - 1);
      in_nbytes = (nb >= 4) ? 2'd0 : 2'(nb);
      cnt = 0;
      while (!in_ready && cnt < 500) begin
        @(negedge clk);
        cnt++;
      end
      if (!in_ready) begin
        errors++;
        checks++;
        $display("FAIL in_timeout: got in_ready=0 expected 1 at word %0d", i);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Consume blocks until one with blk_last; optional stall per block.
  task automatic consume(input int stall, output int nblk, output logic [31:0] w0,
                         output logic [31:0] w14, output logic first0);
    int cnt;
    logic done;
    logic [511:0] snap;
    logic stable_ok;
    nblk = 0; done = 1'b0; w0 = '0; w14 = '0; first0 = 1'b0;
    while (!done) begin
      @(negedge clk);
      cnt = 0;
      while (!blk_valid && cnt < 500) begin
        @(negedge clk);
        cnt++;
      end
      if (!blk_valid) begin
        errors++;
        checks++;
        $display("FAIL blk_timeout: got blk_valid=0 expected 1 after %0d blocks", nblk);
        return;
      end
      if (stall > 0) begin
        snap = blk_data;
        stable_ok = 1'b1;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          if (blk_data !== snap || in_ready !== 1'b0 || blk_valid !== 1'b1) stable_ok = 1'b0;
        end
        check("stall_hold", 512'(stable_ok), 512'(1'b1));
      end
      blk_ready = 1'b1;
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL blk_extra: got unexpected block %h expected none", blk_data);
      end else begin
        check("blk_data", blk_data, exp_q.pop_front());
        check("blk_flags", 512'({blk_first, blk_last}), 512'(exp_fl_q.pop_front()));
      end
      if (nblk == 0) first0 = blk_first;
      nblk++;
      w0   = blk_data[31:0];
      w14  = blk_data[479:448];
      done = blk_last;
      @(posedge clk);
      #1 blk_ready = 1'b0;
    end
  endtask

  initial begin : main
    int          nblk;
    logic [31:0] w0, w14;
    logic        first0;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_nbytes = '0; blk_ready = 1'b0;

    // reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_blk_valid", 512'(blk_valid), 512'(1'b0));
    check("rst_blk_data", blk_data, '0);
    check("rst_blk_first", 512'(blk_first), 512'(1'b0));
    check("rst_blk_last", 512'(blk_last), 512'(1'b0));
    check("rst_in_ready", 512'(in_ready), 512'(1'b0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 512'(in_ready), 512'(1'b1));

    // "abc" single block
    msg_bytes = {8'h61, 8'h62, 8'h63};
    model_push();
    fork
      send_msg(100);
      consume(0, nblk, w0, w14, first0);
    join
    check("abc_nblk", 512'(nblk), 512'(1));
    check("abc_w0", 512'(w0), 512'(32'h80636261));
    check("abc_w14", 512'(w14), 512'(32'h18));
    check("abc_first", 512'(first0), 512'(1'b1));

    // table: {bytes, stall cycles, blocks, final-block word14}
    vecs.push_back('{55,  0, 1, 32'h1B8});
    vecs.push_back('{56,  0, 2, 32'h1C0});
    vecs.push_back('{52,  0, 1, 32'h1A0});
    vecs.push_back('{53,  0, 1, 32'h1A8});
    vecs.push_back('{57,  0, 2, 32'h1C8});
    vecs.push_back('{60,  0, 2, 32'h1E0});
    vecs.push_back('{63,  0, 2, 32'h1F8});
    vecs.push_back('{64,  0, 2, 32'h200});
    vecs.push_back('{128, 0, 3, 32'h400});
    vecs.push_back('{100, 10, 2, 32'h320});
    vecs.push_back('{7,   3, 1, 32'h38});

    for (int t = 0; t < vecs.size(); t++) begin
      msg_bytes.delete();
      for (int i = 0; i < vecs[t].nbytes; i++) msg_bytes.push_back(8'(i*13 + t*5 + 1));
      model_push();
      fork
        send_msg(1000);
        consume(vecs[t].stall, nblk, w0, w14, first0);
      join
      check($sformatf("nblk_%0d", vecs[t].nbytes), 512'(nblk), 512'(vecs[t].exp_nblk));
      check($sformatf("len_%0d", vecs[t].nbytes), 512'(w14), 512'(vecs[t].exp_len));
      if (vecs[t].nbytes == 128 || vecs[t].nbytes == 64)
        check($sformatf("padw0_%0d", vecs[t].nbytes), 512'(w0), 512'(32'h80));
      repeat (2) @(negedge clk);
    end

    // mid-message reset after 7 words, then "abc" must match the clean result
    msg_bytes.delete();
    for (int i = 0; i < 40; i++) msg_bytes.push_back(8'(i + 3));
    send_msg(7);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_blk_valid", 512'(blk_valid), 512'(1'b0));
    check("mid_rst_in_ready", 512'(in_ready), 512'(1'b0));
    rst = 1'b0;
    msg_bytes = {8'h61, 8'h62, 8'h63};
    model_push();
    fork
      send_msg(100);
      consume(0, nblk, w0, w14, first0);
    join
    check("rst_abc_nblk", 512'(nblk), 512'(1));
    check("rst_abc_w0", 512'(w0), 512'(32'h80636261));
    check("rst_abc_w14", 512'(w14), 512'(32'h18));
    check("rst_abc_first", 512'(first0), 512'(1'b1));
    check("exp_q_empty", 512'(exp_q.size()), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
